serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock, with a borrow flip-flop.
- Companion to the combinational half adder in the arithmetic library. Complements it with the subtract direction for area-constrained datapaths, where one bit-cell replaces an N-bit ripple array.
- Start/busy/done handshake.

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/full_subtractor_bit.sv | 25 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(n)), at least 1 so a counter never collapses to 0 bits
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin (in); d, bout (out). Pure combinational.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // first half-subtractor: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // second half-subtractor: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// Ports: clk, rst_n (sync, active-low), start, a, b in;
//        busy, done (1-cycle pulse), diff, bout (final borrow) out.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic d_bit;
  logic bo_bit;

  full_subtractor_bit u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          diff_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          bout_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        // result enters at the MSB and walks down to bit 0
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = bo_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          bout_d  = bo_bit;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor at WIDTH=8 and 13.
// Expected values come from hand tables and a (a-b, a<b) model.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start8, start13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        busy8, done8, bout8;
  logic        busy13, done13, bout13;
  logic [7:0]  diff8;
  logic [12:0] diff13;

  int nvec, nmiss;
  int nacc8, nacc13, ndone8, ndone13;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13),
    .a(a13), .b(b13), .busy(busy13), .done(done13),
    .diff(diff13), .bout(bout13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done8)  ndone8++;
    if (done13) ndone13++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi,
                      input logic [7:0] ed, input logic eb,
                      input string nm);
    int cyc, nb;
    bit seen;
    a8 = ai; b8 = bi; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    nacc8++;
    cyc = 0; nb = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy8) nb++;
      if (done8) seen = 1;
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(cyc), 32'd9);
    chk({nm, " busy_cycles"}, 32'(nb), 32'd9);
    chk({nm, " diff"}, 32'(diff8), 32'(ed));
    chk({nm, " bout"}, 32'(bout8), 32'(eb));
  endtask

  task automatic run13(input logic [12:0] ai, input logic [12:0] bi,
                       input string nm);
    int cyc, nb;
    bit seen;
    logic [12:0] ed;
    ed = ai - bi;
    a13 = ai; b13 = bi; start13 = 1'b1;
    @(posedge clk);
    #1 start13 = 1'b0;
    nacc13++;
    cyc = 0; nb = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy13) nb++;
      if (done13) seen = 1;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd14);
    chk({nm, " busy_cycles"}, 32'(nb), 32'd14);
    chk({nm, " diff"}, 32'(diff13), 32'(ed));
    chk({nm, " bout"}, 32'(bout13), 32'(ai < bi));
  endtask

  vec_t vt[10];

  initial begin
    int cyc, nd;
    bit seen;
    logic [7:0]  ra, rb;
    logic [12:0] sa, sb;
    nvec = 0; nmiss = 0;
    nacc8 = 0; nacc13 = 0; ndone8 = 0; ndone13 = 0;
    vt[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
    vt[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
    vt[2] = '{8'h00,  8'h00,  8'h00, 1'b0};
    vt[3] = '{8'h00,  8'hFF,  8'h01, 1'b1};
    vt[4] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vt[5] = '{8'd10,  8'd4,   8'h06, 1'b0};
    vt[6] = '{8'd200, 8'd100, 8'd100, 1'b0};
    vt[7] = '{8'h80,  8'h81,  8'hFF, 1'b1};
    vt[8] = '{8'hAA,  8'h55,  8'h55, 1'b0};
    vt[9] = '{8'h55,  8'hAA,  8'hAB, 1'b1};

    rst_n = 1'b0; start8 = 1'b0; start13 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; a13 = '1; b13 = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy8", 32'(busy8), 0);
    chk("rst done8", 32'(done8), 0);
    chk("rst diff8", 32'(diff8), 0);
    chk("rst bout8", 32'(bout8), 0);
    chk("rst busy13", 32'(busy13), 0);
    chk("rst diff13", 32'(diff13), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run8(vt[i].a, vt[i].b, vt[i].d, vt[i].bo, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // result held through idle cycles
    run8(8'd3, 8'd5, 8'hFE, 1'b1, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold diff", 32'(diff8), 32'hFE);
      chk("hold bout", 32'(bout8), 1);
      chk("hold busy", 32'(busy8), 0);
    end

    // starts during RUN and DONE are ignored
    a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    nacc8++;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        seen = 1;
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
      end else if (cyc == 3) begin
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    chk("busy_start latency", 32'(cyc), 32'd9);
    chk("busy_start diff", 32'(diff8), 32'h06);
    chk("busy_start bout", 32'(bout8), 0);
    @(negedge clk);
    chk("after_done busy", 32'(busy8), 0);
    chk("after_done done", 32'(done8), 0);
    chk("after_done diff", 32'(diff8), 32'h06);
    run8(8'd7, 8'd2, 8'd5, 1'b0, "start_after_done");

    // reset in the middle of RUN
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(busy8), 0);
    chk("midrst done", 32'(done8), 0);
    chk("midrst diff", 32'(diff8), 0);
    chk("midrst bout", 32'(bout8), 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) nd++;
      @(negedge clk);
    end
    chk("midrst no_done", 32'(nd), 0);
    run8(8'd200, 8'd100, 8'd100, 1'b0, "post_rst");

    // random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, ra - rb, ra < rb, "rnd8");
      @(negedge clk);
      sa = 13'($urandom);
      sb = 13'($urandom);
      run13(sa, sb, "rnd13");
    end

    repeat (3) @(negedge clk);
    chk("done_count8", 32'(ndone8), 32'(nacc8));
    chk("done_count13", 32'(ndone13), 32'(nacc13));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
